dmem_responder: RTL and testbench

//  Data-memory responder: the target end of the datapath's load/store interface.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/ram_sp_be.sv | 28 ++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM encoding, widths and the byte-lane enable function.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  function automatic logic [BE_W-1:0] lane_mask(
    input logic       byte_acc,
    input logic [1:0] lane
  );
    if (!byte_acc) return 4'hF;
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/ram_sp_be.sv
// Single-port synchronous RAM with byte enables.
// Read data is registered; the array has no reset.
module ram_sp_be #(
  parameter int DEPTH     = 1024,
  parameter     INIT_FILE = "",
  localparam int IW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write plus registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: latches one load/store, waits LATENCY
// cycles, then answers with a one-cycle MemReady pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic        ByteAcc,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             write_q, write_d;
  logic             byte_q, byte_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             ram_we;
  logic [3:0]       ram_be;
  logic [IW-1:0]    ram_idx;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;
  logic [1:0]       lane;
  logic             acc_err;
  logic [31:0]      load_val;

  // RAM address follows the live bus while idle so read data is
  // already registered by the time even a LATENCY=1 access completes.
  always_comb begin
    lane      = addr_q[1:0];
    ram_idx   = (state_q == IDLE) ? Addr[IW+1:2] : addr_q[IW+1:2];
    ram_be    = lane_mask(byte_q, lane);
    ram_wdata = byte_q ? {4{wdata_q[7:0]}} : wdata_q;
    acc_err   = ({2'b00, addr_q[31:2]} >= WORD_W'(DEPTH))
              | (!byte_q && (lane != 2'b00));
    load_val  = byte_q ? {24'b0, ram_rdata[{lane, 3'b000} +: 8]}
                       : ram_rdata;
  end

  // Next-state logic: accept, count down, then complete the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    byte_d  = byte_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    ram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (MemReq) begin
          addr_d  = Addr;
          wdata_d = WriteData;
          write_d = MemWrite;
          byte_d  = ByteAcc;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = acc_err;
          ram_we  = write_q & ~acc_err;
          rdata_d = (write_q | acc_err) ? 32'h0 : load_val;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  ram_sp_be #(
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .idx  (ram_idx),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15)
// checked against a word-array model of the memory.
module tb_dmem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = '0;
  logic        wr = 1'b0;
  logic        by = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd [3];
  logic        rdy [3];
  logic        er [3];

  int total = 0;
  int bad = 0;
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .MemReq(req[0]),
    .MemWrite(wr), .ByteAcc(by), .Addr(addr),
    .WriteData(wdata), .ReadData(rd[0]),
    .MemReady(rdy[0]), .MemErr(er[0]));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .MemReq(req[1]),
    .MemWrite(wr), .ByteAcc(by), .Addr(addr),
    .WriteData(wdata), .ReadData(rd[1]),
    .MemReady(rdy[1]), .MemErr(er[1]));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut15 (
    .clk(clk), .reset(reset), .MemReq(req[2]),
    .MemWrite(wr), .ByteAcc(by), .Addr(addr),
    .WriteData(wdata), .ReadData(rd[2]),
    .MemReady(rdy[2]), .MemErr(er[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  // Reference: memory as an array of words, byte lanes by shifting.
  function automatic void m_access(
    input  logic        w,
    input  logic        b,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic [31:0] r,
    output logic        e
  );
    int unsigned idx;
    int unsigned sh;
    logic [31:0] cur;
    idx = a / 4;
    sh  = 8 * (a % 4);
    e   = (idx >= DEPTH) || (!b && (a % 4) != 0);
    r   = 32'h0;
    if (e) return;
    cur = mdl.exists(idx) ? mdl[idx] : 32'h0;
    if (w) begin
      if (b)
        mdl[idx] = (cur & ~(32'hFF << sh)) | ({24'h0, d[7:0]} << sh);
      else
        mdl[idx] = d;
    end else begin
      r = b ? ((cur >> sh) & 32'hFF) : cur;
    end
  endfunction

  // One request on instance k; gap = edges from accept to MemReady
  // (accept edge counts as 1), -1 on timeout; dbl = MemReady one
  // cycle after the pulse.
  task automatic do_req(
    input  int          k,
    input  logic        w,
    input  logic        b,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output logic [31:0] r,
    output logic        e,
    output int          gap,
    output logic        dbl
  );
    int n;
    n = 0;
    gap = -1;
    @(negedge clk);
    wr = w; by = b; addr = a; wdata = d; req[k] = 1'b1;
    while (gap < 0 && n < 40) begin
      @(posedge clk); n++; #1;
      if (rdy[k]) gap = n;
    end
    r = rd[k];
    e = er[k];
    @(negedge clk);
    req[k] = 1'b0;
    @(posedge clk); #1;
    dbl = rdy[k];
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rdy[k] !== 1'b0) begin
        bad++; $display("FAIL rst_ready[%0d] got=%b want=0", k, rdy[k]);
      end
      total++;
      if (er[k] !== 1'b0) begin
        bad++; $display("FAIL rst_err[%0d] got=%b want=0", k, er[k]);
      end
      total++;
      if (rd[k] !== 32'h0) begin
        bad++; $display("FAIL rst_rdata[%0d] got=%h want=0", k, rd[k]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_word();
    logic [31:0] r, mr;
    logic e, me, dbl;
    int g;
    m_access(1, 0, 32'h10, 32'hDEADBEEF, mr, me);
    do_req(0, 1, 0, 32'h10, 32'hDEADBEEF, r, e, g, dbl);
    total++;
    if (g !== 3) begin
      bad++; $display("FAIL str_gap got=%0d want=3", g);
    end
    total++;
    if (e !== 1'b0 || r !== 32'h0) begin
      bad++; $display("FAIL str_resp got=%b/%h want=0/0", e, r);
    end
    total++;
    if (dbl !== 1'b0) begin
      bad++; $display("FAIL str_pulse got=%b want=0", dbl);
    end
    m_access(0, 0, 32'h10, 0, mr, me);
    do_req(0, 0, 0, 32'h10, 0, r, e, g, dbl);
    total++;
    if (r !== 32'hDEADBEEF || e !== 1'b0) begin
      bad++; $display("FAIL ldr_word got=%h want=deadbeef", r);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r, mr;
    logic e, me, dbl;
    int g;
    m_access(1, 1, 32'h11, 32'hAA, mr, me);
    do_req(0, 1, 1, 32'h11, 32'h000000AA, r, e, g, dbl);
    m_access(0, 0, 32'h10, 0, mr, me);
    do_req(0, 0, 0, 32'h10, 0, r, e, g, dbl);
    total++;
    if (r !== 32'hDEADAAEF) begin
      bad++; $display("FAIL strb_merge got=%h want=deadaaef", r);
    end
    m_access(0, 1, 32'h13, 0, mr, me);
    do_req(0, 0, 1, 32'h13, 0, r, e, g, dbl);
    total++;
    if (r !== 32'h000000DE || e !== 1'b0) begin
      bad++; $display("FAIL ldrb_lane3 got=%h want=000000de", r);
    end
  endtask

  task automatic test_errors();
    logic [31:0] r, mr;
    logic e, me, dbl;
    int g;
    m_access(1, 0, 32'h0, 32'h01020304, mr, me);
    do_req(0, 1, 0, 32'h0, 32'h01020304, r, e, g, dbl);
    m_access(0, 0, 32'h0, 0, mr, me);
    do_req(0, 0, 0, 32'h0, 0, r, e, g, dbl);
    do_req(0, 0, 0, 32'h00001002, 0, r, e, g, dbl);
    total++;
    if (e !== 1'b1 || r !== 32'h0 || g !== 3) begin
      bad++;
      $display("FAIL misalign got=%b/%h/%0d want=1/0/3", e, r, g);
    end
    do_req(0, 1, 0, 32'(4 * DEPTH), 32'hFFFFFFFF, r, e, g, dbl);
    total++;
    if (e !== 1'b1 || r !== 32'h0) begin
      bad++; $display("FAIL oob_store got=%b/%h want=1/0", e, r);
    end
    do_req(0, 0, 0, 32'h0, 0, r, e, g, dbl);
    total++;
    if (r !== 32'h01020304 || e !== 1'b0) begin
      bad++; $display("FAIL word0_kept got=%h want=01020304", r);
    end
    do_req(0, 0, 1, 32'(4 * DEPTH + 1), 0, r, e, g, dbl);
    total++;
    if (e !== 1'b1) begin
      bad++; $display("FAIL oob_byte got=%b want=1", e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [3];
    logic [31:0] ex [3];
    logic [31:0] r, mr;
    logic e, me, dbl, pulsed;
    int g, d, p, last;
    for (int i = 0; i < 3; i++) begin
      ba[i] = 32'h40 + 32'(4 * i);
      ex[i] = $urandom;
      m_access(1, 0, ba[i], ex[i], mr, me);
      do_req(0, 1, 0, ba[i], ex[i], r, e, g, dbl);
    end
    @(negedge clk);
    wr = 0; by = 0; addr = ba[0]; req[0] = 1'b1;
    d = 1; p = 0; last = 0;
    for (int t = 1; t <= 24; t++) begin
      @(posedge clk); #1;
      d++;
      pulsed = rdy[0];
      if (pulsed) begin
        if (p < 3) begin
          total++;
          if (rd[0] !== ex[p]) begin
            bad++;
            $display("FAIL b2b_data%0d got=%h want=%h", p, rd[0], ex[p]);
          end
          total++;
          if (t - last !== ((p == 0) ? 3 : 4)) begin
            bad++;
            $display("FAIL b2b_gap%0d got=%0d", p, t - last);
          end
        end
        p++; last = t; d = 0;
      end
      @(negedge clk);
      if (pulsed) begin
        wr = 0; by = 0; wdata = 0;
        if (p < 3) addr = ba[p];
        else req[0] = 1'b0;
      end else if (d >= 2 && req[0]) begin
        addr = $urandom; wdata = $urandom;
        wr = 1'b1; by = 1'($urandom);
      end
    end
    total++;
    if (p !== 3) begin
      bad++; $display("FAIL b2b_count got=%0d want=3", p);
    end
    wr = 0; by = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r, mr;
    logic e, me, dbl;
    int g;
    bit seen;
    m_access(1, 0, 32'h20, 32'hCAFEF00D, mr, me);
    do_req(0, 1, 0, 32'h20, 32'hCAFEF00D, r, e, g, dbl);
    do_req(0, 0, 0, 32'h20, 0, r, e, g, dbl);
    @(negedge clk);
    wr = 1; by = 0; addr = 32'h20; wdata = 32'h12345678;
    req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    total++;
    if (rd[0] !== 32'h0 || rdy[0] !== 1'b0 || er[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got=%h/%b/%b want=0/0/0",
               rd[0], rdy[0], er[0]);
    end
    @(negedge clk);
    req[0] = 1'b0; wr = 0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy[0]) seen = 1;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rdy[0]) seen = 1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL rst_drop got=ready want=none");
    end
    do_req(0, 0, 0, 32'h20, 0, r, e, g, dbl);
    total++;
    if (r !== 32'hCAFEF00D) begin
      bad++; $display("FAIL rst_nowrite got=%h want=cafef00d", r);
    end
  endtask

  task automatic test_latency_sweep();
    logic [31:0] r, dv, a;
    logic e, dbl;
    int g;
    for (int k = 1; k < 3; k++) begin
      a  = 32'h200 + 32'(16 * k);
      dv = $urandom;
      do_req(k, 1, 0, a, dv, r, e, g, dbl);
      total++;
      if (g !== lat_of(k) + 1 || dbl !== 1'b0) begin
        bad++;
        $display("FAIL lat%0d_st got=%0d/%b want=%0d/0",
                 lat_of(k), g, dbl, lat_of(k) + 1);
      end
      do_req(k, 0, 0, a, 0, r, e, g, dbl);
      total++;
      if (g !== lat_of(k) + 1 || r !== dv || dbl !== 1'b0) begin
        bad++;
        $display("FAIL lat%0d_ld got=%0d/%h want=%0d/%h",
                 lat_of(k), g, r, lat_of(k) + 1, dv);
      end
      do_req(k, 0, 1, a + 2, 0, r, e, g, dbl);
      total++;
      if (r !== ((dv >> 16) & 32'hFF) || e !== 1'b0) begin
        bad++;
        $display("FAIL lat%0d_ldb got=%h want=%h",
                 lat_of(k), r, (dv >> 16) & 32'hFF);
      end
      do_req(k, 0, 0, a + 1, 0, r, e, g, dbl);
      total++;
      if (e !== 1'b1 || r !== 32'h0) begin
        bad++;
        $display("FAIL lat%0d_err got=%b/%h want=1/0", lat_of(k), e, r);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, mr, a, dv;
    logic e, me, dbl, w, b;
    int g;
    for (int i = 0; i < 16; i++) begin
      a  = 32'h100 + 32'(4 * i);
      dv = $urandom;
      m_access(1, 0, a, dv, mr, me);
      do_req(0, 1, 0, a, dv, r, e, g, dbl);
    end
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom);
      b  = 1'($urandom);
      dv = $urandom;
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if (!b) a = a & ~32'h3;
      if ($urandom_range(0, 7) == 0)
        a = b ? 32'(4 * DEPTH) + a : a | 32'h2;
      m_access(w, b, a, dv, mr, me);
      do_req(0, w, b, a, dv, r, e, g, dbl);
      total++;
      if (r !== mr || e !== me || g !== 3 || dbl !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d a=%h w=%b b=%b got=%h/%b/%0d want=%h/%b/3",
                 i, a, w, b, r, e, g, mr, me);
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_latency_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
